data_cache_responder: RTL and testbench
=======================================

DATA_CACHE_RESPONDER -- requirements
Module: data_cache_responder

Interface
REQ-001 Parameter NUM_LINES, default 16, number of direct-mapped lines; power of two, at least 2.
REQ-002 Parameter WORDS_PER_LINE, default 4, 32-bit words per line; power of two, at least 2.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous and active-high.
REQ-005 req_i  in  1  core access request, held stable with all core inputs while busy_o=1.
REQ-006 addr_i  in  [31:2]  core word address.
REQ-007 write_en_i  in  4  byte-lane write strobes; 0000 means read, non-zero means write.
REQ-008 wdata_i  in  32  core store data, lane-aligned.
REQ-009 rdata_o  out  32  load data; valid when req_i=1, read, busy_o=0.
REQ-010 busy_o  out  1  stall to core; combinational.
REQ-011 mem_req_o  out  1  backing-memory request.
REQ-012 mem_we_o  out  1  1=memory write, 0=memory read.
REQ-013 mem_addr_o  out  [31:2]  memory word address.
REQ-014 mem_wstrb_o  out  4  memory byte strobes (copy of write_en_i during writes, 0000 on reads).
REQ-015 mem_wdata_o  out  32  memory write data.
REQ-016 mem_rdata_i  in  32  memory read data, valid with mem_ack_i.
REQ-017 mem_ack_i  in  1  one-cycle completion pulse, one per requested word.

Function
REQ-018 Address split: offset = low log2(WORDS_PER_LINE) bits of addr_i; index = next log2(NUM_LINES) bits; tag = remaining upper bits.
REQ-019 Per line, the block SHALL store a valid bit, a tag, and WORDS_PER_LINE data words; hit = valid and tag match at index.
REQ-020 FSM states: IDLE, REFILL, WRITE.
REQ-021 IDLE, read hit: rdata_o = stored word, combinationally; busy_o=0; zero-latency response; state unchanged.
REQ-022 IDLE, read miss: busy_o=1 the same cycle; next state REFILL; line valid bit cleared; refill word counter = 0.
REQ-023 REFILL: mem_req_o=1, mem_we_o=0, mem_addr_o = {tag, index, counter}; words fetched in order 0..WORDS_PER_LINE-1 (no critical-word-first).
REQ-024 REFILL: each mem_ack_i writes mem_rdata_i into word[counter] and increments the counter; mem_req_o stays high between words.
REQ-025 REFILL, ack of last word: tag written, valid set, next state IDLE; the held read then hits and completes with busy_o=0.
REQ-026 IDLE, write (hit or miss): busy_o=1; next state WRITE; no write allocate.
REQ-027 WRITE: mem_req_o=1, mem_we_o=1, mem_addr_o=addr_i, mem_wstrb_o=write_en_i, mem_wdata_o=wdata_i.
REQ-028 WRITE: busy_o = !mem_ack_i. On ack, a write hit SHALL update only strobed byte lanes of the cached word; next state IDLE.
REQ-029 Write-through policy: no dirty state; the cache never evicts to memory.
REQ-030 req_i=0 in IDLE: busy_o=0, mem_req_o=0, no state change.
REQ-031 mem_ack_i while mem_req_o=0 SHALL be ignored.
REQ-032 mem_addr_o, mem_we_o, mem_wstrb_o, mem_wdata_o SHALL be stable while mem_req_o=1 and no ack.
REQ-033 When mem_req_o=0, mem outputs SHALL be 0; rdata_o SHALL be 0 unless a read hits in IDLE.
REQ-034 Index wrap: address fields beyond the tag width are ignored; aliasing lines replace each other on refill.

Reset
REQ-035 rst_i=1 SHALL immediately set the state to IDLE, clear all valid bits, zero the refill counter, and force mem_req_o=0; busy_o SHALL follow REQ-030 and REQ-022.
REQ-036 Reset during REFILL or WRITE SHALL abort the access; the partial line stays invalid; later acks are ignored under REQ-031.
REQ-037 Data and tag arrays need not be reset.

Verification
REQ-038 Reset, then read 0x100 (addr_i=0x40) -> busy_o=1; 4 memory reads at word addresses 0x40..0x43; busy_o=0 and rdata_o = memory word 0x40 after the 4th ack.
REQ-039 Then read addr_i=0x42 -> hit; busy_o=0 the same cycle; no mem_req_o.
REQ-040 Write addr_i=0x41, write_en_i=0011, wdata_i=0xAABBCCDD over cached 0x11223344 -> one memory write with strobe 0011; a later read returns 0x1122CCDD.
REQ-041 Write to an uncached address -> memory write only; a subsequent read of it misses and refills.
REQ-042 Memory acks with 3-cycle gaps during refill -> mem_req_o and mem_addr_o held steady between acks; exactly 4 words written.
REQ-043 Assert rst_i after the 2nd refill ack -> mem_req_o=0 immediately; a re-read of the same address misses and refills all 4 words.

Source files
------------

// File: rtl/data_cache_responder.sv
// data_cache_responder: direct-mapped, write-through, no-write-allocate data cache
// with zero-latency read hits and in-order line refill from a word-wide memory port.
module data_cache_responder #(
   parameter int NUM_LINES      = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic [31:2] addr_i,
   input  logic [3:0]  write_en_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        busy_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:2] mem_addr_o,
   output logic [3:0]  mem_wstrb_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i
);
   localparam int OFF_W = $clog2(WORDS_PER_LINE);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 30 - OFF_W - IDX_W;
   localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS_PER_LINE - 1);
   typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
   state_t state;
   logic [NUM_LINES-1:0] valid;
   logic [TAG_W-1:0] tags [NUM_LINES];
   logic [31:0] data [NUM_LINES*WORDS_PER_LINE];
   logic [OFF_W-1:0] cnt, cnt_nx, off;
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic [31:0] mask;
   logic hit, rd, ack;
   assign off    = addr_i[2 +: OFF_W];
   assign idx    = addr_i[2+OFF_W +: IDX_W];
   assign tag    = addr_i[31 -: TAG_W];
   assign cnt_nx = cnt + OFF_W'(1);
   assign hit    = valid[idx] && tags[idx] == tag;
   assign rd     = write_en_i == 4'b0000;
   assign ack    = mem_req_o && mem_ack_i;
   assign mask   = {{8{mem_wstrb_o[3]}}, {8{mem_wstrb_o[2]}}, {8{mem_wstrb_o[1]}}, {8{mem_wstrb_o[0]}}};
   assign rdata_o = (state == IDLE && req_i && rd && hit) ? data[{idx, off}] : 32'h0;
   assign busy_o  = state == REFILL ? 1'b1 : state == WRITE ? !mem_ack_i : req_i && (!rd || !hit);
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         valid       <= '0;
         cnt         <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wstrb_o <= 4'h0;
         mem_wdata_o <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req_i && !rd) begin
                  state       <= WRITE;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= 1'b1;
                  mem_addr_o  <= addr_i;
                  mem_wstrb_o <= write_en_i;
                  mem_wdata_o <= wdata_i;
               end else if (req_i && !hit) begin
                  // the line is invalid until its last word lands, so an aborted refill leaves no stale hit
                  state      <= REFILL;
                  valid[idx] <= 1'b0;
                  cnt        <= '0;
                  mem_req_o  <= 1'b1;
                  mem_addr_o <= {tag, idx, {OFF_W{1'b0}}};
               end
            end
            REFILL: begin
               if (ack) begin
                  cnt        <= cnt_nx;
                  mem_addr_o <= {tag, idx, cnt_nx};
                  if (cnt == LAST) begin
                     state      <= IDLE;
                     valid[idx] <= 1'b1;
                     mem_req_o  <= 1'b0;
                     mem_addr_o <= '0;
                  end
               end
            end
            WRITE: begin
               if (ack) begin
                  state       <= IDLE;
                  mem_req_o   <= 1'b0;
                  mem_we_o    <= 1'b0;
                  mem_addr_o  <= '0;
                  mem_wstrb_o <= 4'h0;
                  mem_wdata_o <= 32'h0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge clk_i) begin
      if (state == REFILL && ack) data[{idx, cnt}] <= mem_rdata_i;
      if (state == REFILL && ack && cnt == LAST) tags[idx] <= tag;
      if (state == WRITE && ack && hit) data[{idx, off}] <= (data[{idx, off}] & ~mask) | (mem_wdata_o & mask);
   end
endmodule

// File: tb/tb_data_cache_responder.sv
// tb_data_cache_responder: scoreboard bench with a behavioural word memory that
// acks with a programmable gap and checks every memory transaction in order.
module tb_data_cache_responder;
   typedef struct packed {
      logic        we;
      logic [29:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } txn_t;
   logic clk = 1'b0, rst = 1'b1, req = 1'b0;
   logic [29:0] addr = '0;
   logic [3:0]  wen = 4'h0;
   logic [31:0] wdata = 32'h0, rdata, mem_wdata, mem_rdata;
   logic busy, mem_req, mem_we, mem_ack;
   logic [29:0] mem_addr;
   logic [3:0]  mem_wstrb;
   int tests = 0, fails = 0, gap = 0, ack_cnt = 0, wcnt = 0;
   logic [29:0] held;
   txn_t exp_q[$];
   logic [31:0] mem [logic [29:0]];
   data_cache_responder dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .write_en_i(wen),
      .wdata_i(wdata), .rdata_o(rdata), .busy_o(busy), .mem_req_o(mem_req),
      .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wstrb_o(mem_wstrb),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] rd_mem(input logic [29:0] a);
      return mem.exists(a) ? mem[a] : {a[15:0], ~a[15:0]};
   endfunction
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction
   // memory responder: pops the scoreboard on every ack
   initial begin
      txn_t got, e;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (mem_ack) begin
            mem_ack = 1'b0;
            wcnt = 0;
         end else if (mem_req) begin
            if (wcnt == 0) held = mem_addr;
            else begin
               tests++;
               if (mem_addr !== held) begin
                  fails++;
                  $display("FAIL mem_addr_hold: got %h expected %h", mem_addr, held);
               end
            end
            if (wcnt >= gap) begin
               got = {mem_we, mem_addr, mem_wstrb, mem_we ? mem_wdata : 32'h0};
               tests++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL mem_txn_unexpected: got %h expected none", got);
               end else begin
                  e = exp_q.pop_front();
                  if (got !== e) begin
                     fails++;
                     $display("FAIL mem_txn: got %h expected %h", got, e);
                  end
               end
               if (mem_we) mem[mem_addr] = merge(rd_mem(mem_addr), mem_wdata, mem_wstrb);
               else mem_rdata = rd_mem(mem_addr);
               mem_ack = 1'b1;
               ack_cnt++;
            end else wcnt++;
         end else wcnt = 0;
      end
   end
   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      tests++;
      if (busy) begin
         fails++;
         $display("FAIL %s_timeout: busy got %b expected 0", name, busy);
      end
   endtask
   task automatic do_read(input logic [29:0] a, input bit exp_hit, input logic [31:0] exp, input string name);
      @(posedge clk); #1;
      req = 1'b1; addr = a; wen = 4'h0; wdata = 32'h0;
      @(negedge clk); #1;
      tests++;
      if (busy !== !exp_hit) begin
         fails++;
         $display("FAIL %s_busy: got %b expected %b", name, busy, !exp_hit);
      end
      if (exp_hit) begin
         tests++;
         if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL %s_no_mem_req: got %b expected 0", name, mem_req);
         end
      end else for (int k = 0; k < 4; k++) exp_q.push_back('{1'b0, {a[29:2], 2'(k)}, 4'h0, 32'h0});
      wait_idle(name);
      tests++;
      if (rdata !== exp) begin
         fails++;
         $display("FAIL %s_rdata: got %h expected %h", name, rdata, exp);
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_pending: got %0d expected 0", name, exp_q.size());
         exp_q.delete();
      end
      @(posedge clk); #1;
      req = 1'b0;
   endtask
   task automatic do_write(input logic [29:0] a, input logic [3:0] s, input logic [31:0] d, input string name);
      @(posedge clk); #1;
      req = 1'b1; addr = a; wen = s; wdata = d;
      exp_q.push_back('{1'b1, a, s, d});
      @(negedge clk); #1;
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL %s_stall: got %b expected 1", name, busy);
      end
      wait_idle(name);
      @(posedge clk); #1;
      req = 1'b0; wen = 4'h0;
      tests++;
      if (exp_q.size() != 0 || mem_req !== 1'b0) begin
         fails++;
         $display("FAIL %s_done: got pending=%0d mem_req=%b expected 0 0", name, exp_q.size(), mem_req);
         exp_q.delete();
      end
   endtask
   task automatic test_reset;
      tests++;
      if ({busy, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, rdata} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got busy=%b req=%b addr=%h rdata=%h expected all 0", busy, mem_req, mem_addr, rdata);
      end
   endtask
   task automatic test_refill;
      do_read(30'h40, 1'b0, rd_mem(30'h40), "refill");
   endtask
   task automatic test_hit;
      do_read(30'h42, 1'b1, rd_mem(30'h42), "hit");
   endtask
   task automatic test_write_hit;
      do_read(30'h41, 1'b1, 32'h11223344, "pre_write");
      do_write(30'h41, 4'b0011, 32'hAABBCCDD, "write_hit");
      do_read(30'h41, 1'b1, 32'h1122CCDD, "write_hit_read");
   endtask
   task automatic test_back_to_back;
      @(posedge clk); #1;
      req = 1'b1;
      for (int k = 3; k >= 0; k--) begin
         addr = 30'h40 + 30'(k);
         @(negedge clk); #1;
         tests++;
         if (busy !== 1'b0 || rdata !== rd_mem(addr)) begin
            fails++;
            $display("FAIL b2b_%0d: got busy=%b rdata=%h expected 0 %h", k, busy, rdata, rd_mem(addr));
         end
         @(posedge clk); #1;
      end
      req = 1'b0;
   endtask
   task automatic test_write_miss;
      do_write(30'h200, 4'b1111, 32'hDEADBEEF, "write_miss");
      do_read(30'h200, 1'b0, 32'hDEADBEEF, "write_miss_read");
   endtask
   task automatic test_gap;
      int base;
      gap = 3;
      base = ack_cnt;
      do_read(30'h80, 1'b0, rd_mem(30'h80), "gap");
      tests++;
      if (ack_cnt - base != 4) begin
         fails++;
         $display("FAIL gap_acks: got %0d expected 4", ack_cnt - base);
      end
      gap = 0;
      do_read(30'h40, 1'b0, rd_mem(30'h40), "alias_evict");
   endtask
   task automatic test_reset_abort;
      int base, n;
      base = ack_cnt;
      @(posedge clk); #1;
      req = 1'b1; addr = 30'h44; wen = 4'h0;
      for (int k = 0; k < 4; k++) exp_q.push_back('{1'b0, {28'h11, 2'(k)}, 4'h0, 32'h0});
      n = 0;
      while (ack_cnt - base < 2 && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      tests++;
      if (mem_req !== 1'b0 || busy !== 1'b1 || exp_q.size() != 2) begin
         fails++;
         $display("FAIL abort: got mem_req=%b busy=%b pending=%0d expected 0 1 2", mem_req, busy, exp_q.size());
      end
      exp_q.delete();
      req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      do_read(30'h44, 1'b0, rd_mem(30'h44), "abort_reread");
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end
   initial begin
      mem[30'h41] = 32'h11223344;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      test_reset;
      test_refill;
      test_hit;
      test_write_hit;
      test_back_to_back;
      test_write_miss;
      test_gap;
      test_reset_abort;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
